ex_muldiv_unit: RTL and testbench

Multi-cycle multiply/divide unit for the EX stage, generalising the single-cycle ALU path to iterative MULT/MULTU/DIV/DIVU with architectural HI/LO registers. Operands arrive already forwarded, taken after the EX forwarding muxes. The unit runs alongside the ALU and raises `o_busy` so the hazard unit stalls dependent instructions. `DATA_WIDTH` is a parameter, so the same block serves narrower test datapaths.

---
 rtl/ex_muldiv_unit_if.sv | 30 +++
 rtl/ex_muldiv_unit.sv | 207 ++++++++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/ex_muldiv_unit_if.sv
// ex_muldiv_unit_if: request/response bundle between the EX stage and the
// multi-cycle multiply/divide unit.
//   i_start, i_op, i_operand_a, i_operand_b, i_flush : requester -> unit
//   o_busy, o_done, o_hi, o_lo                       : unit -> requester
// The unit attaches through the slave modport and the EX stage through master.
interface ex_muldiv_unit_if #(
  parameter int unsigned DATA_WIDTH = 32
) ();

  logic                  i_start;
  logic [2:0]            i_op;
  logic [DATA_WIDTH-1:0] i_operand_a;
  logic [DATA_WIDTH-1:0] i_operand_b;
  logic                  i_flush;
  logic                  o_busy;
  logic                  o_done;
  logic [DATA_WIDTH-1:0] o_hi;
  logic [DATA_WIDTH-1:0] o_lo;

  modport master (
    output i_start, i_op, i_operand_a, i_operand_b, i_flush,
    input  o_busy, o_done, o_hi, o_lo
  );

  modport slave (
    input  i_start, i_op, i_operand_a, i_operand_b, i_flush,
    output o_busy, o_done, o_hi, o_lo
  );

endinterface

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative MULT/MULTU/DIV/DIVU with architectural HI/LO.
// One multiplier/quotient bit per cycle; MTHI/MTLO write HI/LO in one cycle.
// Ports:
//   i_clk   : clock, rising edge
//   i_reset : asynchronous active-low reset
//   bus     : ex_muldiv_unit_if.slave (start/op/operands/flush in,
//             busy/done/hi/lo out, all outputs registered)
module ex_muldiv_unit #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
  ex_muldiv_unit_if.slave   bus
);

  localparam int unsigned W  = DATA_WIDTH;
  localparam int unsigned W2 = 2 * DATA_WIDTH;
  localparam int unsigned CW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  // Architectural and iteration state
  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [W2-1:0]   r_acc;     // mul: {partial product, multiplier}; div: {remainder, dividend/quotient}
  logic [W-1:0]    r_opnd;    // multiplicand or divisor magnitude
  logic            r_is_div;
  logic            r_neg_q;   // negate product / quotient in FIX
  logic            r_neg_r;   // negate remainder in FIX (dividend sign)
  logic            r_div0;
  logic [W-1:0]    r_hi;
  logic [W-1:0]    r_lo;
  logic            r_busy;
  logic            r_done;

  // Next-state values
  state_t          w_state_nxt;
  logic [CW-1:0]   w_cnt_nxt;
  logic [W2-1:0]   w_acc_nxt;
  logic [W-1:0]    w_opnd_nxt;
  logic            w_is_div_nxt;
  logic            w_neg_q_nxt;
  logic            w_neg_r_nxt;
  logic            w_div0_nxt;
  logic [W-1:0]    w_hi_nxt;
  logic [W-1:0]    w_lo_nxt;
  logic            w_done_nxt;

  // Operand magnitude extraction
  logic            w_signed_in;
  logic            w_a_neg;
  logic            w_b_neg;
  logic [W-1:0]    w_a_mag;
  logic [W-1:0]    w_b_mag;

  always_comb begin
    w_signed_in = ~bus.i_op[0];
    w_a_neg     = w_signed_in & bus.i_operand_a[W-1];
    w_b_neg     = w_signed_in & bus.i_operand_b[W-1];
    w_a_mag     = w_a_neg ? (~bus.i_operand_a + W'(1)) : bus.i_operand_a;
    w_b_mag     = w_b_neg ? (~bus.i_operand_b + W'(1)) : bus.i_operand_b;
  end

  // One shift-add multiply step: add multiplicand when the current multiplier LSB is set, shift right
  logic [W:0]      w_mul_sum;
  logic [W2-1:0]   w_mul_step;

  always_comb begin
    w_mul_sum  = {1'b0, r_acc[W2-1:W]} + {1'b0, r_opnd};
    w_mul_step = r_acc[0] ? {w_mul_sum, r_acc[W-1:1]} : {1'b0, r_acc[W2-1:1]};
  end

  // One restoring-division step: shift in next dividend bit, subtract if it fits
  logic [W:0]      w_rem_sh;
  logic [W:0]      w_rem_sub;
  logic [W2-1:0]   w_div_step;

  always_comb begin
    w_rem_sh  = r_acc[W2-1:W-1];
    w_rem_sub = w_rem_sh - {1'b0, r_opnd};
    if (w_rem_sub[W]) begin
      w_div_step = {w_rem_sh[W-1:0], r_acc[W-2:0], 1'b0};
    end else begin
      w_div_step = {w_rem_sub[W-1:0], r_acc[W-2:0], 1'b1};
    end
  end

  // Sign correction applied in FIX
  logic [W2-1:0]   w_prod_fix;
  logic [W-1:0]    w_quot_fix;
  logic [W-1:0]    w_rem_fix;

  always_comb begin
    w_prod_fix = r_neg_q ? (~r_acc + W2'(1)) : r_acc;
    w_quot_fix = r_neg_q ? (~r_acc[W-1:0] + W'(1)) : r_acc[W-1:0];
    w_rem_fix  = r_neg_r ? (~r_acc[W2-1:W] + W'(1)) : r_acc[W2-1:W];
  end

  // Next-state and datapath control
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_acc_nxt    = r_acc;
    w_opnd_nxt   = r_opnd;
    w_is_div_nxt = r_is_div;
    w_neg_q_nxt  = r_neg_q;
    w_neg_r_nxt  = r_neg_r;
    w_div0_nxt   = r_div0;
    w_hi_nxt     = r_hi;
    w_lo_nxt     = r_lo;
    w_done_nxt   = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (bus.i_start && !bus.i_flush) begin
          case (bus.i_op)
            3'b000, 3'b001, 3'b010, 3'b011: begin
              w_is_div_nxt = bus.i_op[1];
              w_neg_q_nxt  = w_a_neg ^ w_b_neg;
              w_neg_r_nxt  = w_a_neg;
              w_div0_nxt   = (bus.i_operand_b == W'(0));
              // Divide iterates on the dividend; multiply on the multiplier
              w_acc_nxt    = bus.i_op[1] ? {W'(0), w_a_mag} : {W'(0), w_b_mag};
              w_opnd_nxt   = bus.i_op[1] ? w_b_mag : w_a_mag;
              w_cnt_nxt    = CW'(W);
              w_state_nxt  = S_CALC;
            end
            3'b100:  w_hi_nxt = bus.i_operand_a;
            3'b101:  w_lo_nxt = bus.i_operand_a;
            default: ;
          endcase
        end
      end

      S_CALC: begin
        if (bus.i_flush) begin
          w_cnt_nxt   = CW'(0);
          w_state_nxt = S_IDLE;
        end else begin
          w_acc_nxt = r_is_div ? w_div_step : w_mul_step;
          w_cnt_nxt = r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            w_state_nxt = S_FIX;
          end
        end
      end

      S_FIX: begin
        w_state_nxt = S_IDLE;
        if (!bus.i_flush) begin
          w_done_nxt = 1'b1;
          if (r_is_div) begin
            // A zero divisor leaves the raw remainder equal to the dividend,
            // so only the quotient needs forcing
            w_hi_nxt = w_rem_fix;
            w_lo_nxt = r_div0 ? {W{1'b1}} : w_quot_fix;
          end else begin
            {w_hi_nxt, w_lo_nxt} = w_prod_fix;
          end
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= CW'(0);
      r_acc    <= W2'(0);
      r_opnd   <= W'(0);
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_div0   <= 1'b0;
      r_hi     <= W'(0);
      r_lo     <= W'(0);
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_acc    <= w_acc_nxt;
      r_opnd   <= w_opnd_nxt;
      r_is_div <= w_is_div_nxt;
      r_neg_q  <= w_neg_q_nxt;
      r_neg_r  <= w_neg_r_nxt;
      r_div0   <= w_div0_nxt;
      r_hi     <= w_hi_nxt;
      r_lo     <= w_lo_nxt;
      r_busy   <= (w_state_nxt != S_IDLE);
      r_done   <= w_done_nxt;
    end
  end

  assign bus.o_busy = r_busy;
  assign bus.o_done = r_done;
  assign bus.o_hi   = r_hi;
  assign bus.o_lo   = r_lo;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb_ex_muldiv_unit: directed, table-driven checks of ex_muldiv_unit at
// DATA_WIDTH 32 and 8, plus hand sequences for flush, ignored start and reset.
module tb_ex_muldiv_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ex_muldiv_unit_if #(.DATA_WIDTH(32)) if32 ();
  ex_muldiv_unit_if #(.DATA_WIDTH(8))  if8 ();

  ex_muldiv_unit #(.DATA_WIDTH(32)) dut32 (.i_clk(clk), .i_reset(rst_n), .bus(if32));
  ex_muldiv_unit #(.DATA_WIDTH(8))  dut8  (.i_clk(clk), .i_reset(rst_n), .bus(if8));

  int n_chk = 0;
  int n_pass = 0;
  int done_cnt = 0;

  always @(posedge clk) if (if32.o_done) done_cnt <= done_cnt + 1;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Start an op on the 32-bit unit and wait (bounded) for o_done
  task automatic run32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] hi, output logic [31:0] lo,
                       output int lat, output logic busy0, output logic busy_done);
    if32.i_start = 1'b1; if32.i_op = op; if32.i_operand_a = a; if32.i_operand_b = b;
    @(negedge clk);
    if32.i_start = 1'b0;
    busy0 = if32.o_busy;
    lat = 0;
    while (!if32.o_done && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    hi = if32.o_hi; lo = if32.o_lo; busy_done = if32.o_busy;
  endtask

  task automatic run8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                      output logic [7:0] hi, output logic [7:0] lo, output int lat);
    if8.i_start = 1'b1; if8.i_op = op; if8.i_operand_a = a; if8.i_operand_b = b;
    @(negedge clk);
    if8.i_start = 1'b0;
    lat = 0;
    while (!if8.o_done && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    hi = if8.o_hi; lo = if8.o_lo;
  endtask

  // MTHI (op 4) / MTLO (op 5) on the 32-bit unit
  task automatic mt32(input logic [2:0] op, input logic [31:0] a);
    if32.i_start = 1'b1; if32.i_op = op; if32.i_operand_a = a;
    @(negedge clk);
    if32.i_start = 1'b0;
  endtask

  initial begin
    logic [31:0] hi, lo;
    logic [7:0]  hi8, lo8;
    int          lat;
    logic        b0, bd;
    int          d0;

    vecs[0]  = '{3'b000, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[1]  = '{3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[2]  = '{3'b010, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3]  = '{3'b011, 32'h0000_000A, 32'h0000_0000, 32'h0000_000A, 32'hFFFF_FFFF};
    vecs[4]  = '{3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[5]  = '{3'b011, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E};
    vecs[6]  = '{3'b010, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    vecs[7]  = '{3'b010, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF};
    vecs[8]  = '{3'b000, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[9]  = '{3'b001, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780};
    vecs[10] = '{3'b000, 32'h0000_0005, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'hFFFF_FFEC};
    vecs[11] = '{3'b011, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFF};
    vecs[12] = '{3'b010, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'h0000_0002};

    if32.i_start = 1'b0; if32.i_op = 3'b000; if32.i_operand_a = '0; if32.i_operand_b = '0; if32.i_flush = 1'b0;
    if8.i_start = 1'b0;  if8.i_op = 3'b000;  if8.i_operand_a = '0;  if8.i_operand_b = '0;  if8.i_flush = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(if32.o_busy), 32'd0);
    check("rst_done", 32'(if32.o_done), 32'd0);
    check("rst_hi", if32.o_hi, 32'd0);
    check("rst_lo", if32.o_lo, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // MTHI / MTLO single-cycle writes
    mt32(3'b100, 32'h1234_5678);
    check("mthi_hi", if32.o_hi, 32'h1234_5678);
    check("mthi_busy", 32'(if32.o_busy), 32'd0);
    check("mthi_done", 32'(if32.o_done), 32'd0);
    mt32(3'b101, 32'hCAFE_F00D);
    check("mtlo_lo", if32.o_lo, 32'hCAFE_F00D);
    check("mtlo_hi_kept", if32.o_hi, 32'h1234_5678);

    // Table: each op starts in the previous op's o_done cycle (back-to-back)
    for (int i = 0; i < 13; i++) begin
      run32(vecs[i].op, vecs[i].a, vecs[i].b, hi, lo, lat, b0, bd);
      check($sformatf("v%0d_hi", i), hi, vecs[i].hi);
      check($sformatf("v%0d_lo", i), lo, vecs[i].lo);
      check($sformatf("v%0d_latency", i), 32'(lat), 32'd33);
      check($sformatf("v%0d_busy_start", i), 32'(b0), 32'd1);
      check($sformatf("v%0d_busy_done", i), 32'(bd), 32'd0);
    end
    @(negedge clk);
    check("done_one_cycle", 32'(if32.o_done), 32'd0);

    // Flush mid-CALC with an ignored MTLO start
    mt32(3'b100, 32'h1234_5678);
    mt32(3'b101, 32'hCAFE_F00D);
    d0 = done_cnt;
    if32.i_start = 1'b1; if32.i_op = 3'b011; if32.i_operand_a = 32'd100; if32.i_operand_b = 32'd7;
    @(negedge clk);
    if32.i_start = 1'b0;
    repeat (3) @(negedge clk);
    if32.i_start = 1'b1; if32.i_op = 3'b101; if32.i_operand_a = 32'h0000_0BAD;
    @(negedge clk);
    if32.i_start = 1'b0;
    repeat (5) @(negedge clk);
    check("flush_busy_before", 32'(if32.o_busy), 32'd1);
    if32.i_flush = 1'b1;
    @(negedge clk);
    if32.i_flush = 1'b0;
    check("flush_busy_after", 32'(if32.o_busy), 32'd0);
    check("flush_hi_kept", if32.o_hi, 32'h1234_5678);
    check("flush_lo_kept", if32.o_lo, 32'hCAFE_F00D);
    repeat (40) @(negedge clk);
    check("flush_no_done", 32'(done_cnt), 32'(d0));
    check("flush_idle", 32'(if32.o_busy), 32'd0);

    // Flush and start in the same idle cycle: nothing accepted
    if32.i_start = 1'b1; if32.i_flush = 1'b1; if32.i_op = 3'b100; if32.i_operand_a = 32'h0000_0055;
    @(negedge clk);
    check("flush_start_mthi", if32.o_hi, 32'h1234_5678);
    if32.i_op = 3'b010; if32.i_operand_a = 32'd9; if32.i_operand_b = 32'd3;
    @(negedge clk);
    if32.i_start = 1'b0; if32.i_flush = 1'b0;
    check("flush_start_div_busy", 32'(if32.o_busy), 32'd0);

    // DATA_WIDTH = 8
    run8(3'b000, 8'h80, 8'h80, hi8, lo8, lat);
    check("w8_mult_hi", 32'(hi8), 32'h40);
    check("w8_mult_lo", 32'(lo8), 32'h00);
    check("w8_mult_latency", 32'(lat), 32'd9);
    run8(3'b010, 8'hF9, 8'h02, hi8, lo8, lat);
    check("w8_div_hi", 32'(hi8), 32'hFF);
    check("w8_div_lo", 32'(lo8), 32'hFD);
    run8(3'b011, 8'h2A, 8'h00, hi8, lo8, lat);
    check("w8_div0_hi", 32'(hi8), 32'h2A);
    check("w8_div0_lo", 32'(lo8), 32'hFF);

    // Reset mid-CALC of a MULT
    mt32(3'b100, 32'hDEAD_BEEF);
    if32.i_start = 1'b1; if32.i_op = 3'b000; if32.i_operand_a = 32'hFFFF_FFFD; if32.i_operand_b = 32'd7;
    @(negedge clk);
    if32.i_start = 1'b0;
    repeat (5) @(negedge clk);
    check("rstmid_busy_before", 32'(if32.o_busy), 32'd1);
    d0 = done_cnt;
    rst_n = 1'b0;
    @(negedge clk);
    check("rstmid_busy", 32'(if32.o_busy), 32'd0);
    check("rstmid_hi", if32.o_hi, 32'd0);
    check("rstmid_lo", if32.o_lo, 32'd0);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("rstmid_no_done", 32'(done_cnt), 32'(d0));
    check("rstmid_idle", 32'(if32.o_busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
